// File: rtl/mem_dump_seq.sv
// Memory dump sequencer: takes the RAM address/write-enable away from the CPU
// and walks word addresses 0..LAST_ADDR on step presses or a periodic timer.
module mem_dump_seq #(
    parameter int unsigned AUTO_DIV  = 100000000,
    parameter logic [7:0]  LAST_ADDR = 8'hFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dump_mem,
    input  logic        step,
    input  logic        auto_en,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_we,
    output logic [15:0] addr_out,
    output logic        we_out,
    output logic        cpu_hold,
    output logic        dump_active,
    output logic        wrapped
);

    localparam int unsigned   TW        = (AUTO_DIV > 1) ? $clog2(AUTO_DIV) : 1;
    localparam logic [TW-1:0] TIMER_MAX = TW'(AUTO_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ENTER,
        S_DUMP,
        S_EXIT
    } state_e;

    state_e        state_q;
    logic [7:0]    ptr_q;
    logic [TW-1:0] timer_q;
    logic          wrapped_q;
    logic          step_q;
    logic          hold_q;
    logic          active_q;

    logic          step_ev;
    logic          auto_ev;
    logic          advance;
    logic [7:0]    ptr_d;
    logic          wrapped_d;

    // A cycle where dump_mem has dropped is the hand-back cycle, so it never advances.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        ptr_d     = ptr_q;
        wrapped_d = wrapped_q;
        step_ev   = step && !step_q;
        auto_ev   = (state_q == S_DUMP) && auto_en && (timer_q == TIMER_MAX);
        advance   = (state_q == S_DUMP) && dump_mem && (step_ev || auto_ev);
        if (advance) begin
            if (ptr_q == LAST_ADDR) begin
                ptr_d     = 8'h00;
                wrapped_d = 1'b1;
            end else begin
                ptr_d = ptr_q + 8'd1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            ptr_q     <= 8'h00;
            timer_q   <= '0;
            wrapped_q <= 1'b0;
            step_q    <= 1'b0;
            hold_q    <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            step_q <= step;

            if ((state_q == S_DUMP) && dump_mem && auto_en) begin
                timer_q <= auto_ev ? '0 : timer_q + TW'(1);
            end else begin
                timer_q <= '0;
            end

            case (state_q)
                S_IDLE: begin
                    if (dump_mem) begin
                        state_q   <= S_ENTER;
                        hold_q    <= 1'b1;
                        ptr_q     <= 8'h00;
                        wrapped_q <= 1'b0;
                    end
                end
                S_ENTER: begin
                    state_q   <= S_DUMP;
                    active_q  <= 1'b1;
                    ptr_q     <= 8'h00;
                    wrapped_q <= 1'b0;
                end
                S_DUMP: begin
                    if (!dump_mem) begin
                        state_q  <= S_EXIT;
                        active_q <= 1'b0;
                    end else begin
                        ptr_q     <= ptr_d;
                        wrapped_q <= wrapped_d;
                    end
                end
                S_EXIT: begin
                    state_q <= S_IDLE;
                    hold_q  <= 1'b0;
                end
                default: begin
                    state_q  <= S_IDLE;
                    hold_q   <= 1'b0;
                    active_q <= 1'b0;
                end
            endcase
        end
    end

    // The CPU owns the RAM port only in IDLE; ENTER and EXIT show its address but never its writes.
    always_comb begin
        addr_out = cpu_addr;
        we_out   = 1'b0;
        case (state_q)
            S_IDLE:  we_out   = cpu_we;
            S_DUMP:  addr_out = {8'h00, ptr_q};
            default: ;
        endcase
    end

    assign cpu_hold    = hold_q;
    assign dump_active = active_q;
    assign wrapped     = wrapped_q;

endmodule

// File: tb/tb_mem_dump_seq.sv
// Directed bench for mem_dump_seq: one instance with a full 8-bit dump range
// and one with LAST_ADDR = 3, both stepping every 4 cycles in auto mode.
module tb_mem_dump_seq;

    logic        clk;
    logic        reset;
    logic        dump_mem;
    logic        step;
    logic        auto_en;
    logic [15:0] cpu_addr;
    logic        cpu_we;

    logic [15:0] addr_out,   w_addr_out;
    logic        we_out,     w_we_out;
    logic        cpu_hold,   w_cpu_hold;
    logic        dump_active, w_dump_active;
    logic        wrapped,    w_wrapped;

    int n_checks = 0;
    int n_fail   = 0;

    mem_dump_seq #(.AUTO_DIV(4), .LAST_ADDR(8'hFF)) dut (
        .clk(clk), .reset(reset), .dump_mem(dump_mem), .step(step), .auto_en(auto_en),
        .cpu_addr(cpu_addr), .cpu_we(cpu_we), .addr_out(addr_out), .we_out(we_out),
        .cpu_hold(cpu_hold), .dump_active(dump_active), .wrapped(wrapped)
    );

    mem_dump_seq #(.AUTO_DIV(4), .LAST_ADDR(8'h03)) dut_w (
        .clk(clk), .reset(reset), .dump_mem(dump_mem), .step(step), .auto_en(auto_en),
        .cpu_addr(cpu_addr), .cpu_we(cpu_we), .addr_out(w_addr_out), .we_out(w_we_out),
        .cpu_hold(w_cpu_hold), .dump_active(w_dump_active), .wrapped(w_wrapped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b0;
        dump_mem = 1'b0;
        step     = 1'b0;
        auto_en  = 1'b0;
        cpu_addr = 16'h1234;
        cpu_we   = 1'b1;

        #3;
        check("rst_addr",   addr_out,    16'h1234);
        check("rst_we",     we_out,      1'b1);
        check("rst_hold",   cpu_hold,    1'b0);
        check("rst_active", dump_active, 1'b0);
        check("rst_wrap",   wrapped,     1'b0);

        cyc(2);
        reset = 1'b1;
        #1;
        check("idle_addr", addr_out, 16'h1234);
        check("idle_we",   we_out,   1'b1);
        check("idle_hold", cpu_hold, 1'b0);

        cpu_addr = 16'hABCD;
        cpu_we   = 1'b0;
        #1;
        check("idle_addr2", addr_out, 16'hABCD);
        check("idle_we2",   we_out,   1'b0);

        // Enter dump mode with the CPU still trying to write
        cpu_we   = 1'b1;
        dump_mem = 1'b1;
        cyc(1);
        check("enter_hold",   cpu_hold,    1'b1);
        check("enter_we",     we_out,      1'b0);
        check("enter_active", dump_active, 1'b0);
        cyc(1);
        check("dump_addr",   addr_out,    16'h0000);
        check("dump_hold",   cpu_hold,    1'b1);
        check("dump_we",     we_out,      1'b0);
        check("dump_active", dump_active, 1'b1);
        check("dump_wrap",   wrapped,     1'b0);

        // Long press counts once, second press counts once more
        step = 1'b1;
        cyc(10);
        check("step_hold_addr", addr_out, 16'h0001);
        step = 1'b0;
        cyc(1);
        step = 1'b1;
        cyc(1);
        step = 1'b0;
        cyc(1);
        check("step_two_addr", addr_out, 16'h0002);

        // Leave dump mode; a step coinciding with the drop must not advance
        dump_mem = 1'b0;
        cpu_addr = 16'h5678;
        step     = 1'b1;
        cyc(1);
        check("exit_hold",   cpu_hold,    1'b1);
        check("exit_we",     we_out,      1'b0);
        check("exit_addr",   addr_out,    16'h5678);
        check("exit_active", dump_active, 1'b0);
        cyc(1);
        check("back_hold", cpu_hold, 1'b0);
        check("back_we",   we_out,   1'b1);
        check("back_addr", addr_out, 16'h5678);
        step = 1'b0;

        // Auto stepping: re-entry restarts at 0, then one advance every 4 cycles
        auto_en  = 1'b1;
        dump_mem = 1'b1;
        cyc(2);
        check("auto_start",   addr_out,   16'h0000);
        check("auto_start_w", w_addr_out, 16'h0000);
        for (int k = 1; k <= 4; k++) begin
            cyc(3);
            check("auto_hold_w", w_addr_out, 32'((k - 1) % 4));
            cyc(1);
            check("auto_step",   addr_out,   32'(k));
            check("auto_step_w", w_addr_out, 32'(k % 4));
            check("auto_wrap_w", w_wrapped,  (k == 4) ? 32'd1 : 32'd0);
        end
        check("auto_nowrap", wrapped, 1'b0);

        // Step press landing on the same edge as an auto event advances once
        cyc(3);
        step = 1'b1;
        cyc(1);
        step = 1'b0;
        check("coinc_addr",   addr_out,   16'h0005);
        check("coinc_addr_w", w_addr_out, 16'h0001);
        check("coinc_wrap_w", w_wrapped,  1'b1);

        // Asynchronous reset in the middle of a dump
        reset = 1'b0;
        #1;
        check("mid_rst_addr",   addr_out,    16'h5678);
        check("mid_rst_we",     we_out,      1'b1);
        check("mid_rst_hold",   cpu_hold,    1'b0);
        check("mid_rst_active", dump_active, 1'b0);
        check("mid_rst_wrap_w", w_wrapped,   1'b0);
        #1;
        reset = 1'b1;
        cyc(1);
        check("rerst_enter_hold",   cpu_hold,    1'b1);
        check("rerst_enter_active", dump_active, 1'b0);
        check("rerst_enter_we",     we_out,      1'b0);
        cyc(1);
        check("rerst_dump_addr",   addr_out,    16'h0000);
        check("rerst_dump_active", dump_active, 1'b1);

        // Wrap again, then confirm the flag survives exit and clears on re-entry
        cyc(16);
        check("wrap2_addr_w", w_addr_out, 16'h0000);
        check("wrap2_flag_w", w_wrapped,  1'b1);
        check("wrap2_addr",   addr_out,   16'h0004);
        dump_mem = 1'b0;
        cyc(1);
        check("wrap2_exit_flag", w_wrapped, 1'b1);
        cyc(1);
        check("wrap2_idle_flag", w_wrapped, 1'b1);
        check("wrap2_idle_hold", w_cpu_hold, 1'b0);

        // Press held through ENTER must not count as a step
        auto_en  = 1'b0;
        step     = 1'b1;
        dump_mem = 1'b1;
        cyc(1);
        check("reent_enter_wrap_w", w_wrapped, 1'b0);
        cyc(3);
        check("held_step_addr",   addr_out,   16'h0000);
        check("held_step_addr_w", w_addr_out, 16'h0000);
        check("reent_dump_wrap_w", w_wrapped, 1'b0);
        step     = 1'b0;
        dump_mem = 1'b0;
        cyc(2);
        check("reent_back_hold", cpu_hold, 1'b0);

        // dump_mem dropped during ENTER: one DUMP cycle, then EXIT
        dump_mem = 1'b1;
        cyc(1);
        dump_mem = 1'b0;
        check("short_enter_hold", cpu_hold, 1'b1);
        cyc(1);
        check("short_dump_active", dump_active, 1'b1);
        check("short_dump_addr",   addr_out,    16'h0000);
        cyc(1);
        check("short_exit_active", dump_active, 1'b0);
        check("short_exit_hold",   cpu_hold,    1'b1);
        check("short_exit_we",     we_out,      1'b0);
        cyc(1);
        check("short_idle_hold", cpu_hold, 1'b0);
        check("short_idle_we",   we_out,   1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_dump_seq.md
MEM_DUMP_SEQ -- requirements
Module: mem_dump_seq

Interface
REQ-001 SHALL have parameter AUTO_DIV, default 100000000, meaning clk cycles per auto-step (1 s at 100 MHz).
REQ-002 SHALL have parameter LAST_ADDR, default 8'hFF, meaning the highest dumped RAM word address before wrap.
REQ-003 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port dump_mem  input  1  level request for dump mode (debounced switch).
REQ-006 SHALL have port step  input  1  debounced step button, level; the block edge-detects it internally.
REQ-007 SHALL have port auto_en  input  1  enable for timer-driven stepping while dumping.
REQ-008 SHALL have port cpu_addr  input  16  CPU memory address.
REQ-009 SHALL have port cpu_we  input  1  CPU memory write enable (mw_en).
REQ-010 SHALL have port addr_out  output  16  address to RAM and display.
REQ-011 SHALL have port we_out  output  1  write enable to RAM.
REQ-012 SHALL have port cpu_hold  output  1  high = CPU clock stepping must be blocked.
REQ-013 SHALL have port dump_active  output  1  high while in DUMP state.
REQ-014 SHALL have port wrapped  output  1  sticky flag, dump address has wrapped LAST_ADDR->0.

Function
REQ-015 SHALL implement FSM states IDLE, ENTER, DUMP, EXIT.
REQ-016 IDLE: addr_out = cpu_addr, we_out = cpu_we, cpu_hold = 0 (combinational pass-through).
REQ-017 IDLE -> ENTER on dump_mem = 1 at clock edge.
REQ-018 ENTER (1 cycle): cpu_hold = 1, we_out = 0, dump pointer cleared to 0, wrapped cleared, timer cleared; unconditionally -> DUMP.
REQ-019 DUMP: addr_out = {8'h00, ptr}, we_out = 0, cpu_hold = 1, dump_active = 1.
REQ-020 DUMP -> EXIT when dump_mem = 0; no pointer advance in that cycle.
REQ-021 EXIT (1 cycle): addr_out = cpu_addr, we_out = 0, cpu_hold = 1; -> IDLE.
REQ-022 Step event = rising edge of step (step = 1 now, registered step = 0 last cycle); exactly one advance per press regardless of hold length.
REQ-023 Auto event = timer reaching AUTO_DIV-1 while auto_en = 1 in DUMP; timer then reloads 0; timer held at 0 when auto_en = 0 or not in DUMP.
REQ-024 On step event or auto event (either or both, same cycle) in DUMP: ptr advances by exactly 1.
REQ-025 Advance at ptr = LAST_ADDR: ptr -> 0 and wrapped -> 1; wrapped stays 1 until ENTER or reset.
REQ-026 Step events outside DUMP are ignored; the edge register still tracks step so a press held through ENTER does not advance.
REQ-027 dump_mem toggling 1->0 during ENTER: ENTER still completes, DUMP lasts one cycle, then EXIT.
REQ-028 ptr is 8 bits; upper 8 addr_out bits are 0 in DUMP.
REQ-029 cpu_we asserted during ENTER, DUMP or EXIT is never propagated to we_out.

Reset
REQ-030 reset = 0 SHALL asynchronously force state IDLE, ptr = 0, timer = 0, wrapped = 0, step edge register = 0.
REQ-031 During reset: addr_out = cpu_addr, we_out = cpu_we, cpu_hold = 0, dump_active = 0, wrapped = 0.
REQ-032 Reset asserted mid-DUMP SHALL abort without passing through EXIT; after release, dump_mem still 1 -> ENTER on next edge.

Verification
REQ-033 Reset released, dump_mem = 0, cpu_addr = 16'h1234, cpu_we = 1 -> addr_out = 16'h1234, we_out = 1, cpu_hold = 0.
REQ-034 dump_mem 0->1 -> one ENTER cycle then DUMP; addr_out = 16'h0000, cpu_hold = 1, we_out = 0 with cpu_we = 1.
REQ-035 In DUMP, step held high 10 cycles, then low, then one more press -> ptr = 2, addr_out = 16'h0002.
REQ-036 AUTO_DIV = 4, auto_en = 1, LAST_ADDR = 8'h03 -> addr_out 0,1,2,3,0 every 4 cycles; wrapped = 1 after 3->0; step pulse coinciding with auto event advances only 1.
REQ-037 dump_mem 1->0 in DUMP -> one EXIT cycle (cpu_hold = 1, we_out = 0, addr_out = cpu_addr), then IDLE pass-through; re-entry clears ptr and wrapped.
REQ-038 reset pulsed low mid-DUMP with ptr = 8'h05 -> immediately IDLE outputs, ptr = 0; after release with dump_mem = 1 -> ENTER then DUMP at address 0.
